// File: rtl/pipeline_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the five-stage pipeline hazard/stall controller.
//   - state_e     : controller FSM states (RUN / MEM_WAIT / ERROR)
//   - ctrl_t      : bundle of pipeline register enables and bubble flushes
//   - CTRL_*      : the fixed control patterns the controller can emit
//   - DEFAULT_MAX_WAIT : default data-memory wait budget before a timeout
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int DEFAULT_MAX_WAIT = 16;
  localparam int REG_IDX_W        = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // Field order matches the bit patterns of the CTRL_* constants below:
  // five enables (front to back of the pipe), then the two bubble loads.
  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic id_ex_enable;
    logic ex_mem_enable;
    logic mem_wb_enable;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Everything advances, nothing squashed.
  localparam ctrl_t CTRL_NORMAL   = 7'b11111_00;
  // Everything advances; the two younger instructions are wrong-path.
  localparam ctrl_t CTRL_REDIRECT = 7'b11111_11;
  // Hold PC and IF/ID, let EX onward drain, one bubble into ID/EX.
  localparam ctrl_t CTRL_LOAD_USE = 7'b00111_01;
  // Whole pipe frozen with its contents intact.
  localparam ctrl_t CTRL_FREEZE   = 7'b00000_00;
  // Nothing advances and both front registers are loaded with bubbles.
  localparam ctrl_t CTRL_RESET    = 7'b00000_11;

endpackage

// File: rtl/pipeline_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_controller_if
// Bundles the hazard-observation inputs and the pipeline control outputs
// exchanged between the datapath and the pipeline controller.
//   master : datapath side  (drives register indices / stage status,
//                            receives enables and flushes)
//   slave  : controller side (the reverse)
// Signals:
//   id_rs1, id_rs2, ex_rd, ex_load, ex_redirect, mem_req, dmem_ready
//   pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable
//   if_id_flush, id_ex_flush
// ---------------------------------------------------------------------------
interface pipeline_controller_if;
  import pipeline_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_load;
  logic                 ex_redirect;
  logic                 mem_req;
  logic                 dmem_ready;

  logic                 pc_enable;
  logic                 if_id_enable;
  logic                 id_ex_enable;
  logic                 ex_mem_enable;
  logic                 mem_wb_enable;
  logic                 if_id_flush;
  logic                 id_ex_flush;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_load, ex_redirect, mem_req, dmem_ready,
    input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
           mem_wb_enable, if_id_flush, id_ex_flush
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_load, ex_redirect, mem_req, dmem_ready,
    output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
           mem_wb_enable, if_id_flush, id_ex_flush
  );

endinterface

// File: rtl/pipeline_controller_hazard.sv
// ---------------------------------------------------------------------------
// hazard_detector
// Purely combinational load-use comparator.
// Ports:
//   id_rs1, id_rs2 (in)  source registers of the instruction in ID
//   ex_rd          (in)  destination register of the instruction in EX
//   ex_load        (in)  EX instruction is a load
//   load_use       (out) ID needs a value the EX load has not produced yet
// ---------------------------------------------------------------------------
module hazard_detector
  import pipeline_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_load,
  output logic                 load_use
);

  // x0 is hard-wired to zero, so a load "writing" it never creates a hazard.
  always_comb begin
    load_use = ex_load && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
// Central stall/flush controller for a five-stage in-order pipeline.
// Handles data-memory wait states (with timeout), control redirects and
// load-use hazards, and keeps two saturating performance counters.
// Parameters:
//   MAX_WAIT : stalled memory cycles tolerated before declaring a bus error
//   CNT_W    : width of the performance counters
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus           : pipeline_controller_if.slave (hazard inputs, enables,
//                   flushes)
//   bus_error     : sticky data-memory timeout flag
//   stall_cycles  : cycles in which the PC was held (outside ERROR)
//   flush_events  : cycles in which any bubble was inserted
//   state         : current FSM state, for debug
// ---------------------------------------------------------------------------
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_controller_if.slave  bus,
  output logic                  bus_error,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
  output logic [1:0]            state
);

  // The wait counter only ever has to hold 0 .. MAX_WAIT-1.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               bus_error_q, bus_error_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  ctrl_t              ctrl;
  logic               load_use;
  logic               mem_stall;

  hazard_detector u_hazard (
    .id_rs1   (bus.id_rs1),
    .id_rs2   (bus.id_rs2),
    .ex_rd    (bus.ex_rd),
    .ex_load  (bus.ex_load),
    .load_use (load_use)
  );

  always_comb begin
    mem_stall = bus.mem_req && !bus.dmem_ready;
  end

  // Next-state and output decode. Reset overrides everything and loads
  // bubbles. In RUN and MEM_WAIT a memory stall freezes the whole pipe,
  // so a redirect or load-use seen meanwhile is simply held until the
  // ready cycle, where it is acted on exactly as in RUN. The wait counter
  // counts every frozen cycle, including the first one seen in RUN, so
  // MAX_WAIT stalled cycles in a row land the FSM in ERROR. Encoding 3 is
  // never entered but is steered back to RUN with the pipe frozen.
  always_comb begin
    ctrl        = CTRL_FREEZE;
    state_d     = state_q;
    wait_d      = wait_q;
    bus_error_d = bus_error_q;

    if (rst) begin
      ctrl        = CTRL_RESET;
      state_d     = RUN;
      wait_d      = '0;
      bus_error_d = 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mem_stall) begin
            ctrl = CTRL_FREEZE;
            if (wait_q == WAIT_LAST) begin
              state_d     = ERROR;
              wait_d      = '0;
              bus_error_d = 1'b1;
            end else begin
              state_d = MEM_WAIT;
              wait_d  = wait_q + WAIT_W'(1);
            end
          end else begin
            state_d = RUN;
            wait_d  = '0;
            if (bus.ex_redirect) begin
              ctrl = CTRL_REDIRECT;
            end else if (load_use) begin
              ctrl = CTRL_LOAD_USE;
            end else begin
              ctrl = CTRL_NORMAL;
            end
          end
        end
        ERROR: begin
          ctrl        = CTRL_FREEZE;
          state_d     = ERROR;
          bus_error_d = 1'b1;
        end
        default: begin
          ctrl    = CTRL_FREEZE;
          state_d = RUN;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Performance counters. Time spent dead in ERROR is not a stall worth
  // profiling, so it is excluded; both counters stick at all-ones.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (rst) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!ctrl.pc_enable && (state_q != ERROR) && (stall_q != '1)) begin
        stall_d = stall_q + CNT_W'(1);
      end
      if ((ctrl.if_id_flush || ctrl.id_ex_flush) && (flush_q != '1)) begin
        flush_d = flush_q + CNT_W'(1);
      end
    end
  end

  // State register; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_q      <= wait_d;
    bus_error_q <= bus_error_d;
    stall_q     <= stall_d;
    flush_q     <= flush_d;
  end

  assign bus.pc_enable     = ctrl.pc_enable;
  assign bus.if_id_enable  = ctrl.if_id_enable;
  assign bus.id_ex_enable  = ctrl.id_ex_enable;
  assign bus.ex_mem_enable = ctrl.ex_mem_enable;
  assign bus.mem_wb_enable = ctrl.mem_wb_enable;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_flush   = ctrl.id_ex_flush;

  assign bus_error    = bus_error_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller
// Scoreboard bench for pipeline_controller. Two instances share the clock:
// dut (MAX_WAIT=16, CNT_W=32) carries the main directed sequence, dut_sat
// (CNT_W=4) is held in reset until the counter saturation sequence.
// Each directed vector carries its hand-computed expected outputs, which
// are queued when the vector is driven and checked by a separate monitor
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_controller;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_sat;

  pipeline_controller_if main_if ();
  pipeline_controller_if sat_if ();

  logic        main_bus_error, sat_bus_error;
  logic [31:0] main_stall, main_flush;
  logic [3:0]  sat_stall, sat_flush;
  logic [1:0]  main_state, sat_state;

  pipeline_controller #(.MAX_WAIT(16), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (main_if),
    .bus_error    (main_bus_error),
    .stall_cycles (main_stall),
    .flush_events (main_flush),
    .state        (main_state)
  );

  pipeline_controller #(.MAX_WAIT(16), .CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst          (rst_sat),
    .bus          (sat_if),
    .bus_error    (sat_bus_error),
    .stall_cycles (sat_stall),
    .flush_events (sat_flush),
    .state        (sat_state)
  );

  typedef struct {
    string       name;
    bit          which;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [1:0]  st;
    logic        be;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Compare one expected record against the selected instance.
  task automatic checkOutput(input exp_t e);
    logic [4:0]  a_en;
    logic [1:0]  a_fl;
    logic [1:0]  a_st;
    logic        a_be;
    logic [31:0] a_stall;
    logic [31:0] a_flush;
    if (e.which == 1'b0) begin
      a_en    = {main_if.pc_enable, main_if.if_id_enable, main_if.id_ex_enable,
                 main_if.ex_mem_enable, main_if.mem_wb_enable};
      a_fl    = {main_if.if_id_flush, main_if.id_ex_flush};
      a_st    = main_state;
      a_be    = main_bus_error;
      a_stall = main_stall;
      a_flush = main_flush;
    end else begin
      a_en    = {sat_if.pc_enable, sat_if.if_id_enable, sat_if.id_ex_enable,
                 sat_if.ex_mem_enable, sat_if.mem_wb_enable};
      a_fl    = {sat_if.if_id_flush, sat_if.id_ex_flush};
      a_st    = sat_state;
      a_be    = sat_bus_error;
      a_stall = {28'd0, sat_stall};
      a_flush = {28'd0, sat_flush};
    end
    tests_run++;
    if (a_en !== e.en || a_fl !== e.fl || a_st !== e.st || a_be !== e.be ||
        a_stall !== e.stall || a_flush !== e.flush) begin
      tests_failed++;
      $display("[TB] FAIL %s: got en=%b fl=%b st=%0d be=%b stall=%0d flush=%0d, expected en=%b fl=%b st=%0d be=%b stall=%0d flush=%0d",
               e.name, a_en, a_fl, a_st, a_be, a_stall, a_flush,
               e.en, e.fl, e.st, e.be, e.stall, e.flush);
    end
  endtask

  // Monitor: one queued expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic clearInputs();
    main_if.id_rs1 = '0; main_if.id_rs2 = '0; main_if.ex_rd = '0;
    main_if.ex_load = 1'b0; main_if.ex_redirect = 1'b0;
    main_if.mem_req = 1'b0; main_if.dmem_ready = 1'b0;
    sat_if.id_rs1 = '0; sat_if.id_rs2 = '0; sat_if.ex_rd = '0;
    sat_if.ex_load = 1'b0; sat_if.ex_redirect = 1'b0;
    sat_if.mem_req = 1'b0; sat_if.dmem_ready = 1'b0;
  endtask

  // Drive one cycle of inputs to the chosen instance and queue its
  // expected outputs for that same cycle.
  task automatic applyStimulus(input string name, input bit which, input logic r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ld,
                               input logic rdr, input logic mq, input logic dr,
                               input logic [4:0] en, input logic [1:0] fl,
                               input logic [1:0] st, input logic be,
                               input int stall, input int flush);
    exp_t e;
    @(posedge clk);
    #1;
    clearInputs();
    if (which == 1'b0) begin
      rst = r;
      main_if.id_rs1 = rs1; main_if.id_rs2 = rs2; main_if.ex_rd = rd;
      main_if.ex_load = ld; main_if.ex_redirect = rdr;
      main_if.mem_req = mq; main_if.dmem_ready = dr;
    end else begin
      rst = 1'b0;
      rst_sat = r;
      sat_if.id_rs1 = rs1; sat_if.id_rs2 = rs2; sat_if.ex_rd = rd;
      sat_if.ex_load = ld; sat_if.ex_redirect = rdr;
      sat_if.mem_req = mq; sat_if.dmem_ready = dr;
    end
    e.name  = name;
    e.which = which;
    e.en    = en;
    e.fl    = fl;
    e.st    = st;
    e.be    = be;
    e.stall = 32'(stall);
    e.flush = 32'(flush);
    sb.push_back(e);
  endtask

  initial begin
    int drain;
    rst = 1'b1;
    rst_sat = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);

    //            name                     w  r  rs1 rs2 rd ld rd mq dr  en        fl     st be stall flush
    applyStimulus("reset",                 0, 1, 0,  0,  0, 0, 0, 0, 0, 5'b00000, 2'b11, 0, 0, 0,  0);
    applyStimulus("normal_after_reset",    0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0,  0);
    applyStimulus("load_use_rs1",          0, 0, 5,  0,  5, 1, 0, 0, 0, 5'b00111, 2'b01, 0, 0, 0,  0);
    applyStimulus("after_load_use",        0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 1,  1);
    applyStimulus("x0_excluded",           0, 0, 0,  0,  0, 1, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 1,  1);
    applyStimulus("load_use_rs2",          0, 0, 3,  7,  7, 1, 0, 0, 0, 5'b00111, 2'b01, 0, 0, 1,  1);
    applyStimulus("load_no_match",         0, 0, 3,  4,  7, 1, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 2,  2);
    applyStimulus("redirect_over_lu",      0, 0, 5,  0,  5, 1, 1, 0, 0, 5'b11111, 2'b11, 0, 0, 2,  2);
    applyStimulus("after_redirect",        0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 2,  3);
    applyStimulus("mem_stall_1",           0, 0, 0,  0,  0, 0, 0, 1, 0, 5'b00000, 2'b00, 0, 0, 2,  3);
    applyStimulus("mem_stall_2",           0, 0, 0,  0,  0, 0, 0, 1, 0, 5'b00000, 2'b00, 1, 0, 3,  3);
    applyStimulus("mem_stall_3",           0, 0, 0,  0,  0, 0, 0, 1, 0, 5'b00000, 2'b00, 1, 0, 4,  3);
    applyStimulus("ready_with_redirect",   0, 0, 0,  0,  0, 0, 1, 1, 1, 5'b11111, 2'b11, 1, 0, 5,  3);
    applyStimulus("back_to_run",           0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 5,  4);
    applyStimulus("stall_beats_redirect",  0, 0, 0,  0,  0, 0, 1, 1, 0, 5'b00000, 2'b00, 0, 0, 5,  4);
    applyStimulus("ready_with_load_use",   0, 0, 5,  0,  5, 1, 0, 1, 1, 5'b00111, 2'b01, 1, 0, 6,  4);
    applyStimulus("run_after_lu_wait",     0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 7,  5);

    // 20 stalled cycles: 16 counted stalls, ERROR visible from cycle 17.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus($sformatf("timeout_%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0,
                    5'b00000, 2'b00,
                    (i == 1) ? 2'd0 : ((i <= 16) ? 2'd1 : 2'd2),
                    (i >= 17) ? 1'b1 : 1'b0,
                    7 + ((i - 1 < 16) ? (i - 1) : 16), 5);
    end

    applyStimulus("error_ignores_ready",   0, 0, 0,  0,  0, 0, 0, 1, 1, 5'b00000, 2'b00, 2, 1, 23, 5);
    applyStimulus("error_ignores_redir",   0, 0, 5,  0,  5, 1, 1, 0, 0, 5'b00000, 2'b00, 2, 1, 23, 5);
    applyStimulus("reset_in_error",        0, 1, 0,  0,  0, 0, 0, 1, 0, 5'b00000, 2'b11, 2, 1, 23, 5);
    applyStimulus("run_after_err_reset",   0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0,  0);
    applyStimulus("stall_before_reset",    0, 0, 0,  0,  0, 0, 0, 1, 0, 5'b00000, 2'b00, 0, 0, 0,  0);
    applyStimulus("reset_in_mem_wait",     0, 1, 0,  0,  0, 0, 1, 1, 0, 5'b00000, 2'b11, 1, 0, 1,  0);
    applyStimulus("run_after_wait_reset",  0, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0,  0);

    // 4-bit counters: 20 load-use cycles, both counters stop at 15.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus($sformatf("sat_load_use_%0d", i), 1, 0, 5, 0, 5, 1, 0, 0, 0,
                    5'b00111, 2'b01, 2'd0, 1'b0,
                    (i - 1 < 15) ? (i - 1) : 15,
                    (i - 1 < 15) ? (i - 1) : 15);
    end
    applyStimulus("sat_hold",              1, 0, 0,  0,  0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 15, 15);

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sb.size() > 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MAX_WAIT, default 16: maximum number of MEM_WAIT cycles before the controller declares a bus timeout.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-006 ex_rd  input  5  destination register index of the instruction in EX.
REQ-007 ex_load  input  1  the instruction in EX is a load.
REQ-008 ex_redirect  input  1  taken branch or jal/jalr resolved in EX.
REQ-009 mem_req  input  1  the MEM-stage instruction accesses data memory this cycle.
REQ-010 dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  output  1 each  pipeline register write enables.
REQ-012 if_id_flush, id_ex_flush  output  1 each  load a bubble (NOP) into the register.
REQ-013 bus_error  output  1  sticky data-memory timeout flag.
REQ-014 stall_cycles, flush_events  output  CNT_W each  performance counters.
REQ-015 state  output  2  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have three states: RUN=0, MEM_WAIT=1, ERROR=2. Encoding 3 is unreachable and SHALL recover to RUN.
REQ-017 Load-use hazard SHALL be defined as ex_load && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
REQ-018 Memory stall SHALL be defined as mem_req && !dmem_ready.
REQ-019 Outputs SHALL be combinational from state and inputs. In RUN or MEM_WAIT, the priority order SHALL be: memory stall > redirect > load-use > normal.
- Memory stall: all five enables 0, no flushes. Next state SHALL be MEM_WAIT.
- Redirect: all enables 1, if_id_flush=1, id_ex_flush=1. Load-use is ignored because the ID instruction is wrong-path.
- Load-use: pc_enable=0, if_id_enable=0, other enables 1, id_ex_flush=1. Exactly one bubble is inserted, with no state change.
- Normal: all enables 1, no flushes.
REQ-020 In MEM_WAIT, a wait counter SHALL increment each cycle the memory stall persists. The cycle dmem_ready=1, REQ-019 SHALL apply as in RUN, next state SHALL be RUN, and the counter SHALL clear.
REQ-021 When a memory stall persists while the wait counter equals MAX_WAIT-1, the next state SHALL be ERROR.
REQ-022 In ERROR, all enables SHALL be 0, all flushes 0, and bus_error=1. ERROR SHALL be left only by rst.
REQ-023 stall_cycles SHALL increment on every non-reset cycle with pc_enable=0 while state!=ERROR.
REQ-024 flush_events SHALL increment on every cycle with if_id_flush=1 or id_ex_flush=1 outside reset.
REQ-025 Both counters SHALL saturate at all-ones and never wrap.
REQ-026 Redirect and load-use SHALL have 0-cycle latency: they act in the same cycle the inputs assert.
REQ-027 A redirect or load-use arriving during MEM_WAIT SHALL take effect on the dmem_ready cycle. The inputs are held stable by the freeze.

Reset
REQ-028 While rst=1: all enables SHALL be 0, if_id_flush=1, and id_ex_flush=1.
REQ-029 On a clock edge with rst=1: state SHALL become RUN, and the wait counter, bus_error, stall_cycles and flush_events SHALL become 0.
REQ-030 A reset asserted in MEM_WAIT or ERROR SHALL take priority over all other inputs.

Structure
REQ-031 A shared package pipeline_pkg SHALL hold the state enum type (RUN/MEM_WAIT/ERROR) and the default MAX_WAIT constant.
REQ-032 The load-use comparator SHALL be a separate combinational sub-module named hazard_detector (inputs id_rs1, id_rs2, ex_rd, ex_load; output load_use).
REQ-033 The remaining logic (FSM, wait counter, output decode, counters) SHALL be in pipeline_controller, 120-400 lines of RTL.

Verification
REQ-034 Load-use: ex_load=1, ex_rd=5, id_rs1=5 for one cycle -> pc_enable=0, if_id_enable=0, id_ex_flush=1 for exactly that cycle; stall_cycles=1, flush_events=1.
REQ-035 x0 exclusion: ex_load=1, ex_rd=0, id_rs2=0 -> all enables 1, no flush, counters unchanged.
REQ-036 Redirect with load-use: ex_redirect=1 plus the REQ-034 hazard in the same cycle -> pc_enable=1, both flushes 1, stall_cycles unchanged.
REQ-037 Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, state=1 during the wait, RUN after, stall_cycles=3.
REQ-038 Timeout: mem_req=1, dmem_ready=0 held for 20 cycles with MAX_WAIT=16 -> state=2 and bus_error=1 from cycle 17. A later dmem_ready=1 has no effect. rst=1 for one cycle -> state=0, bus_error=0, counters 0.
REQ-039 Counter saturation: CNT_W=4 with 20 load-use stalls -> stall_cycles stays at 15.
